// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory macro between fetch and load/store: one transaction in flight,
// data wins collisions unless fetch has waited through STARVE_MAX data grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_mask,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_ack,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_mask,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int MASK_W = DATA_W / 8;
   localparam int SC_W   = $clog2(STARVE_MAX + 1);
   localparam int LAT_W  = $clog2(MEM_LAT + 1);
   localparam logic [SC_W-1:0]  STARVE_SAT = SC_W'(STARVE_MAX);
   localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);

   arb_state_e          state_r, state_s;
   arb_owner_e          own_r, own_s, grant_own_s;
   logic                grant_s;
   logic                own_we_r, own_we_s;
   logic [LAT_W-1:0]    lat_cnt_r, lat_cnt_s;
   logic [SC_W-1:0]     starve_cnt_r, starve_cnt_s;
   logic                mem_en_r, mem_en_s, mem_we_r, mem_we_s;
   logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
   logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
   logic [MASK_W-1:0]   mem_mask_r, mem_mask_s;
   logic                if_ack_r, if_ack_s, dm_ack_r, dm_ack_s;
   logic [DATA_W-1:0]   if_rdata_r, if_rdata_s, dm_rdata_r, dm_rdata_s;
   logic                busy_r, busy_s;

   // Fixed data priority, overridden once fetch has been passed over STARVE_MAX times.
   always_comb begin
      grant_s     = 1'b0;
      grant_own_s = OWN_IF;
      if (dm_req && if_req) begin
         grant_s = 1'b1;
         if (starve_cnt_r == STARVE_SAT) begin
            grant_own_s = OWN_IF;
         end else begin
            grant_own_s = OWN_DM;
         end
      end else if (dm_req) begin
         grant_s     = 1'b1;
         grant_own_s = OWN_DM;
      end else if (if_req) begin
         grant_s     = 1'b1;
         grant_own_s = OWN_IF;
      end else begin
         grant_s     = 1'b0;
         grant_own_s = OWN_IF;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: state_s = WAIT;
         WAIT: begin
            if (lat_cnt_r == LAT_ONE) begin
               state_s = ACK;
            end else begin
               state_s = WAIT;
            end
         end
         ACK:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Next values of every registered output and counter.
   always_comb begin
      own_s        = own_r;
      own_we_s     = own_we_r;
      lat_cnt_s    = '0;
      starve_cnt_s = starve_cnt_r;
      mem_en_s     = 1'b0;
      mem_we_s     = 1'b0;
      mem_addr_s   = '0;
      mem_wdata_s  = '0;
      mem_mask_s   = '0;
      if_ack_s     = 1'b0;
      dm_ack_s     = 1'b0;
      if_rdata_s   = if_rdata_r;
      dm_rdata_s   = dm_rdata_r;
      busy_s       = (state_s != IDLE);
      case (state_r)
         IDLE: begin
            if (grant_s && (grant_own_s == OWN_DM)) begin
               own_s       = OWN_DM;
               own_we_s    = dm_we;
               mem_en_s    = 1'b1;
               mem_we_s    = dm_we;
               mem_addr_s  = dm_addr;
               mem_wdata_s = dm_wdata;
               mem_mask_s  = dm_mask;
            end else if (grant_s) begin
               own_s       = OWN_IF;
               own_we_s    = 1'b0;
               mem_en_s    = 1'b1;
               mem_addr_s  = if_addr;
            end else begin
               own_s       = own_r;
            end
            // Only data grants made while fetch is waiting count toward starvation.
            if (grant_s && (grant_own_s == OWN_IF)) begin
               starve_cnt_s = '0;
            end else if (!if_req) begin
               starve_cnt_s = '0;
            end else if (grant_s && (starve_cnt_r != STARVE_SAT)) begin
               starve_cnt_s = starve_cnt_r + SC_W'(1);
            end else begin
               starve_cnt_s = starve_cnt_r;
            end
         end
         ISSUE: lat_cnt_s = LAT_LOAD;
         WAIT: begin
            lat_cnt_s = lat_cnt_r - LAT_ONE;
            if ((lat_cnt_r == LAT_ONE) && (own_r == OWN_IF)) begin
               if_ack_s   = 1'b1;
               if_rdata_s = mem_rdata;
            end else if (lat_cnt_r == LAT_ONE) begin
               dm_ack_s = 1'b1;
               if (!own_we_r) begin
                  dm_rdata_s = mem_rdata;
               end else begin
                  dm_rdata_s = dm_rdata_r;
               end
            end else begin
               if_ack_s = 1'b0;
            end
         end
         ACK:     lat_cnt_s = '0;
         default: lat_cnt_s = '0;
      endcase
   end

   // Datapath, counters and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         own_r        <= OWN_IF;
         own_we_r     <= 1'b0;
         lat_cnt_r    <= '0;
         starve_cnt_r <= '0;
         mem_en_r     <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
         mem_mask_r   <= '0;
         if_ack_r     <= 1'b0;
         dm_ack_r     <= 1'b0;
         if_rdata_r   <= '0;
         dm_rdata_r   <= '0;
         busy_r       <= 1'b0;
      end else begin
         own_r        <= own_s;
         own_we_r     <= own_we_s;
         lat_cnt_r    <= lat_cnt_s;
         starve_cnt_r <= starve_cnt_s;
         mem_en_r     <= mem_en_s;
         mem_we_r     <= mem_we_s;
         mem_addr_r   <= mem_addr_s;
         mem_wdata_r  <= mem_wdata_s;
         mem_mask_r   <= mem_mask_s;
         if_ack_r     <= if_ack_s;
         dm_ack_r     <= dm_ack_s;
         if_rdata_r   <= if_rdata_s;
         dm_rdata_r   <= dm_rdata_s;
         busy_r       <= busy_s;
      end
   end

   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_mask  = mem_mask_r;
   assign if_ack    = if_ack_r;
   assign dm_ack    = dm_ack_r;
   assign if_rdata  = if_rdata_r;
   assign dm_rdata  = dm_rdata_r;
   assign busy      = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified instruction/data memory of the RV32I core between the fetch unit and the load/store unit. One transaction is in flight at a time. Fixed priority favours data, and a starvation bound guarantees fetch progress. The block sits between the core's two memory request ports and the memory macro, and sequences the macro's enable, write and latency timing.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `DATA_W/8` mask bits.
- `MEM_LAT`, default 2: cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid. Legal range is 1 or more.
- `STARVE_MAX`, default 4: maximum consecutive data grants while fetch waits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_addr` in `ADDR_W`: fetch address; stable while `if_req`.
- `if_rdata` out `DATA_W`: fetched word; valid with `if_ack`, held afterwards.
- `if_ack` out 1: one-cycle completion pulse.
- `dm_req` in 1: data request; held until `dm_ack`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in `ADDR_W`, `dm_wdata` in `DATA_W`, `dm_mask` in `DATA_W/8`: store/load address, data and byte mask.
- `dm_rdata` out `DATA_W`: load data; valid with `dm_ack`.
- `dm_ack` out 1: one-cycle completion pulse.
- `mem_en` out 1, `mem_we` out 1: memory access strobe and write strobe.
- `mem_addr` out `ADDR_W`, `mem_wdata` out `DATA_W`, `mem_mask` out `DATA_W/8`: memory address, write data and mask.
- `mem_rdata` in `DATA_W`: memory read data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- **IDLE.** Sample requests and grant as follows:
  - If only one requester is high, grant it.
  - If both are high, grant data unless `starve_cnt == STARVE_MAX`; in that case grant fetch.
  - On a grant, latch the owner and the request fields, then go to ISSUE.
- **ISSUE.** Drive the access for exactly one cycle:
  - `mem_en=1`, plus `mem_addr`, `mem_wdata` and `mem_mask`.
  - `mem_we=dm_we` for a data owner; `mem_we=0` for fetch.
  - Load `lat_cnt=MEM_LAT`, then go to WAIT.
- **WAIT.** Decrement `lat_cnt`. When `lat_cnt` reaches 1, capture `mem_rdata` into the owner's rdata register. For stores, leave `dm_rdata` unchanged. Then go to ACK.
- **ACK.** Pulse the owner's ack for one cycle, then return to IDLE.
  - A request still high in the following IDLE cycle counts as a new request.
- **starve_cnt** (width `$clog2(STARVE_MAX+1)`):
  - Increments on each data grant made while `if_req=1`.
  - Clears on a fetch grant, or in IDLE when `if_req=0`.
  - Saturates at `STARVE_MAX`.
- A store with `dm_mask=0` is issued and acked normally; the memory writes no bytes.
- Only the owner's ack ever pulses. The non-owner's rdata is never modified.

## Timing
- A request high in IDLE cycle t produces:
  - `mem_en` in cycle t+1;
  - `mem_rdata` sampled in cycle t+1+`MEM_LAT`;
  - ack and rdata valid in cycle t+2+`MEM_LAT`.
- Back-to-back throughput is one transaction per `MEM_LAT`+3 cycles.
- Reset values: every output is 0, including `if_rdata`, `dm_rdata` and `busy`. State is IDLE; `starve_cnt` and `lat_cnt` are 0.
- Requests are ignored in any cycle where `rst=1`.
- Reset mid-transaction (ISSUE, WAIT or ACK): the transaction is abandoned. No ack is issued, and `mem_en`/`mem_we` are 0 from the next cycle.
- Simultaneous `if_req` and `dm_req` in IDLE follow the priority and starvation rules above.
- Requests that arrive while `busy=1` wait. There is no queueing beyond the held `req` line.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/ACK);
  - the owner encoding (OWN_IF=0, OWN_DM=1).
- No sub-module is needed. The FSM, latency counter and starvation counter stay inline in a single module.

## Test plan
All scenarios use `MEM_LAT=2` and `STARVE_MAX=4`.
- **Single fetch.** `if_req=1`, `if_addr=0x100` in cycle 0.
  - `mem_en=1`, `mem_addr=0x100`, `mem_we=0` in cycle 1.
  - Memory returns 0x00500093 in cycle 3.
  - `if_ack=1`, `if_rdata=0x00500093` in cycle 4 only.
- **Store.** `dm_req=1`, `dm_we=1`, `dm_addr=0x200`, `dm_wdata=0xDEADBEEF`, `dm_mask=4'b0011`.
  - `mem_we=1` and `mem_mask=0011` for exactly one cycle.
  - `dm_ack` in cycle 4; `dm_rdata` unchanged.
- **Collision.** `if_req` and `dm_req` both rise in the same cycle.
  - Data is granted first.
  - `if_ack` follows one transaction period later (cycle 9).
- **Starvation.** `dm_req` held continuously while `if_req` is held.
  - Exactly 4 `dm_ack` pulses occur, then one `if_ack`, then data resumes.
  - `starve_cnt` returns to 0 after the fetch grant.
- **Reset mid-WAIT.** `rst=1` for one cycle during WAIT of a load.
  - No `dm_ack`; all outputs are 0; `busy=0`.
  - A new `if_req` afterwards completes with normal latency.
- **Zero-mask store.** `dm_we=1`, `dm_mask=0`.
  - Issued and acked in cycle 4; memory contents unchanged.
